kbd_scan_proc: RTL and testbench
================================

KBD_SCAN_PROC -- requirements
Module: kbd_scan_proc

Interface
REQ-001 SHALL have parameter CNT_WRAP, default 99, meaning the highest press count before wrap to 0 (legal range 9..99).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ps2_data, input, 8 bits: scan byte at the head of the ps2_keyboard FIFO, valid while ps2_ready=1.
REQ-005 SHALL have port ps2_ready, input, 1 bit: ps2_keyboard FIFO non-empty.
REQ-006 SHALL have port nextdata_n, output, 1 bit: active-low FIFO pop to ps2_keyboard, registered.
REQ-007 SHALL have port key_down, output, 1 bit: a tracked key is currently held.
REQ-008 SHALL have port key_code, output, 8 bits: make code of the held key; 0x00 when none is held.
REQ-009 SHALL have port key_ext, output, 1 bit: held key was E0-prefixed.
REQ-010 SHALL have port key_ascii, output, 8 bits: lowercase ASCII of key_code; 0x00 if unmapped or key_ext=1.
REQ-011 SHALL have ports cnt_ones and cnt_tens, output, 4 bits each: BCD press count, driving seg_x and seg_y.

Function
REQ-012 SHALL implement FSM states IDLE, POP and GAP.
- IDLE: ps2_ready=1 -> POP; otherwise stay.
- POP: nextdata_n=0 for exactly this one cycle; capture ps2_data; -> GAP.
- GAP: nextdata_n=1; no sampling; -> IDLE.
REQ-013 SHALL keep nextdata_n=1 in every state except POP; the minimum spacing between pops is 3 cycles.
REQ-014 SHALL make outputs reflect a popped byte in the cycle after POP (1-cycle latency).
REQ-015 SHALL handle captured byte 0xE0 as follows: set ext_pend; no output change.
REQ-016 SHALL handle captured byte 0xF0 as follows: set brk_pend; no output change.
REQ-017 SHALL treat any other byte with brk_pend=0 as a make code.
- Not key_down, or code/ext differs from held key: key_code=byte, key_ext=ext_pend, key_down=1, count +1.
- Same code and ext as held key (typematic repeat): no count change.
REQ-018 SHALL treat any other byte with brk_pend=1 as a break code.
- Matches held code and ext: key_down=0, key_code=0x00, key_ext=0.
- Does not match: ignored.
REQ-019 SHALL clear both ext_pend and brk_pend after every non-prefix byte.
REQ-020 SHALL accept prefixes in either order (E0 F0 xx and F0 E0 xx both form an extended break).
REQ-021 SHALL keep the count as BCD {cnt_tens,cnt_ones}.
- Ones wrap 9->0 with tens increment.
- At value CNT_WRAP, the next increment gives 00.
REQ-022 SHALL produce key_ascii combinationally from key_code and key_ext, covering set-2 codes for a-z and 0-9 (top row); all other codes give 0x00.
- Required pairs: 0x1C->0x61 'a', 0x1A->0x7A 'z', 0x45->0x30 '0', 0x16->0x31 '1'.
REQ-023 SHALL ignore ps2_ready while in POP or GAP.
REQ-024 SHALL treat a 0x00 data byte as a make code like any other (no special case).

Reset
REQ-025 SHALL, while rst=1, force: state=IDLE, nextdata_n=1, key_down=0, key_code=0x00, key_ext=0, ext_pend=0, brk_pend=0, cnt_ones=0, cnt_tens=0.
REQ-026 SHALL, when rst is asserted during POP, not pop: rst dominates, so nextdata_n=1 in that cycle and the byte stays in the FIFO.
REQ-027 SHALL resume at IDLE in the first cycle after rst deasserts; a pending ps2_ready=1 starts POP in that cycle.

Verification
REQ-028 SHALL cover the simple keystroke: FIFO 0x1C,0xF0,0x1C.
- After the first pop: key_down=1, key_code=0x1C, key_ascii=0x61, count=01.
- After the third pop: key_down=0, key_code=0x00, count=01.
- Exactly 3 single-cycle nextdata_n pulses, each at least 3 cycles apart.
REQ-029 SHALL cover typematic repeat: 0x16 x5 then 0xF0,0x16 -> count=01; key_ascii=0x31 while held; released at the end.
REQ-030 SHALL cover the extended key: 0xE0,0x75,0xE0,0xF0,0x75.
- Held: key_ext=1, key_code=0x75, key_ascii=0x00.
- Final state: released, count=01.
REQ-031 SHALL cover wrap: 100 distinct-key make/break pairs -> count reads 99 after the 99th and 00 after the 100th; tens carries at 09->10.
REQ-032 SHALL cover mismatched break and reset: make 0x1C then 0xF0,0x1A -> still held 0x1C.
- rst pulsed during a POP cycle: all outputs at reset values, nextdata_n=1 that cycle.
- The unpopped byte is consumed after release.

Source files
------------

// File: rtl/kbd_scan_proc_if.sv
// PS/2 keyboard FIFO handshake: head-of-FIFO byte, non-empty flag, active-low pop.
interface kbd_scan_proc_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       nextdata_n;

  // FIFO side
  modport master (output ps2_data, output ps2_ready, input nextdata_n);
  // Scan-code processor side
  modport slave  (input ps2_data, input ps2_ready, output nextdata_n);
endinterface

// File: rtl/kbd_scan_proc.sv
// PS/2 set-2 scan-code processor: pops the keyboard FIFO, tracks one held key,
// decodes it to lowercase ASCII and keeps a BCD count of distinct key presses.
module kbd_scan_proc #(
  parameter int unsigned CNT_WRAP = 99
) (
  input  logic             clk,
  input  logic             rst,
  kbd_scan_proc_if.slave   ps2,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic [3:0]       cnt_ones,
  output logic [3:0]       cnt_tens
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WRAP_TENS = CNT_W'(CNT_WRAP / 10);
  localparam logic [CNT_W-1:0] WRAP_ONES = CNT_W'(CNT_WRAP % 10);
  localparam logic [DATA_W-1:0] BYTE_EXT = 8'hE0;
  localparam logic [DATA_W-1:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t            state;
  logic              pop_n_q;
  logic              ext_pend;
  logic              brk_pend;
  logic [DATA_W-1:0] data_c;
  logic              same_key_c;
  logic              cnt_at_wrap_c;

  // Reset overrides a pop already under way so the FIFO head is not lost.
  assign ps2.nextdata_n = pop_n_q | rst;

  // Incoming byte refers to the key currently held (same code and prefix).
  always_comb begin
    data_c        = ps2.ps2_data;
    same_key_c    = key_down && (key_code == data_c) && (key_ext == ext_pend);
    cnt_at_wrap_c = (cnt_tens == WRAP_TENS) && (cnt_ones == WRAP_ONES);
  end

  // Pop FSM plus prefix/make/break tracking and BCD press counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pop_n_q  <= 1'b1;
      key_down <= 1'b0;
      key_code <= 8'h00;
      key_ext  <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      cnt_ones <= 4'd0;
      cnt_tens <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ps2.ps2_ready) begin
            state   <= POP;
            pop_n_q <= 1'b0;
          end
        end
        POP: begin
          state   <= GAP;
          pop_n_q <= 1'b1;
          if (data_c == BYTE_EXT) begin
            ext_pend <= 1'b1;
          end else if (data_c == BYTE_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            if (!brk_pend) begin
              if (!same_key_c) begin
                key_code <= data_c;
                key_ext  <= ext_pend;
                key_down <= 1'b1;
                if (cnt_at_wrap_c) begin
                  cnt_ones <= 4'd0;
                  cnt_tens <= 4'd0;
                end else if (cnt_ones == 4'd9) begin
                  cnt_ones <= 4'd0;
                  cnt_tens <= cnt_tens + 4'd1;
                end else begin
                  cnt_ones <= cnt_ones + 4'd1;
                end
              end
            end else if (same_key_c) begin
              key_down <= 1'b0;
              key_code <= 8'h00;
              key_ext  <= 1'b0;
            end
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          pop_n_q <= 1'b1;
        end
      endcase
    end
  end

  // Set-2 make code to lowercase ASCII; extended keys never map.
  always_comb begin
    key_ascii = 8'h00;
    if (!key_ext) begin
      case (key_code)
        8'h1C: key_ascii = 8'h61;
        8'h32: key_ascii = 8'h62;
        8'h21: key_ascii = 8'h63;
        8'h23: key_ascii = 8'h64;
        8'h24: key_ascii = 8'h65;
        8'h2B: key_ascii = 8'h66;
        8'h34: key_ascii = 8'h67;
        8'h33: key_ascii = 8'h68;
        8'h43: key_ascii = 8'h69;
        8'h3B: key_ascii = 8'h6A;
        8'h42: key_ascii = 8'h6B;
        8'h4B: key_ascii = 8'h6C;
        8'h3A: key_ascii = 8'h6D;
        8'h31: key_ascii = 8'h6E;
        8'h44: key_ascii = 8'h6F;
        8'h4D: key_ascii = 8'h70;
        8'h15: key_ascii = 8'h71;
        8'h2D: key_ascii = 8'h72;
        8'h1B: key_ascii = 8'h73;
        8'h2C: key_ascii = 8'h74;
        8'h3C: key_ascii = 8'h75;
        8'h2A: key_ascii = 8'h76;
        8'h1D: key_ascii = 8'h77;
        8'h22: key_ascii = 8'h78;
        8'h35: key_ascii = 8'h79;
        8'h1A: key_ascii = 8'h7A;
        8'h45: key_ascii = 8'h30;
        8'h16: key_ascii = 8'h31;
        8'h1E: key_ascii = 8'h32;
        8'h26: key_ascii = 8'h33;
        8'h25: key_ascii = 8'h34;
        8'h2E: key_ascii = 8'h35;
        8'h36: key_ascii = 8'h36;
        8'h3D: key_ascii = 8'h37;
        8'h3E: key_ascii = 8'h38;
        8'h46: key_ascii = 8'h39;
        default: key_ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scan_proc.sv
// Bench for kbd_scan_proc: FIFO model feeding the DUT, byte-level reference model.
module tb_kbd_scan_proc;

  localparam int unsigned CNT_WRAP = 99;

  logic       clk;
  logic       rst;
  logic       key_down;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;

  kbd_scan_proc_if ifc ();

  kbd_scan_proc #(.CNT_WRAP(CNT_WRAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2       (ifc),
    .key_down  (key_down),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_ascii (key_ascii),
    .cnt_ones  (cnt_ones),
    .cnt_tens  (cnt_tens)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fifo[$];
  int         pop_times[$];

  // Key table: set-2 make codes in the order of the characters in KEY_CHARS.
  logic [7:0] codes [36] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Reference model state
  logic       m_down;
  logic [7:0] m_code;
  logic       m_ext;
  logic       m_epend;
  logic       m_bpend;
  int         m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO head presented away from the sampling edge.
  always @(negedge clk) begin
    ifc.ps2_ready = (fifo.size() != 0);
    ifc.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // FIFO pop on an active-low strobe, logging when each pop happened.
  always @(posedge clk) begin
    cyc++;
    if (ifc.nextdata_n === 1'b0) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pop_times.push_back(cyc);
    end
  end

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext);
    string chars;
    chars = "abcdefghijklmnopqrstuvwxyz0123456789";
    ascii_of = 8'h00;
    if (!ext) begin
      for (int i = 0; i < 36; i++)
        if (codes[i] == code) ascii_of = chars[i];
    end
  endfunction

  task automatic model_reset();
    m_down = 1'b0; m_code = 8'h00; m_ext = 1'b0;
    m_epend = 1'b0; m_bpend = 1'b0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    if (b == 8'hE0) m_epend = 1'b1;
    else if (b == 8'hF0) m_bpend = 1'b1;
    else begin
      same = m_down && (m_code == b) && (m_ext == m_epend);
      if (!m_bpend) begin
        if (!same) begin
          m_code = b; m_ext = m_epend; m_down = 1'b1;
          m_cnt = (m_cnt == CNT_WRAP) ? 0 : m_cnt + 1;
        end
      end else if (same) begin
        m_down = 1'b0; m_code = 8'h00; m_ext = 1'b0;
      end
      m_epend = 1'b0; m_bpend = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".key_down"},  32'(key_down),  32'(m_down));
    check({tag, ".key_code"},  32'(key_code),  32'(m_code));
    check({tag, ".key_ext"},   32'(key_ext),   32'(m_ext));
    check({tag, ".key_ascii"}, 32'(key_ascii), 32'(ascii_of(m_code, m_ext)));
    check({tag, ".cnt_ones"},  32'(cnt_ones),  32'(m_cnt % 10));
    check({tag, ".cnt_tens"},  32'(cnt_tens),  32'(m_cnt / 10));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Push one byte into an empty FIFO, wait for its pop, check one cycle later.
  task automatic send_one(input logic [7:0] b, input string tag);
    bit got;
    got = 1'b0;
    fifo.push_back(b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (ifc.nextdata_n === 1'b0) got = 1'b1;
    end
    check({tag, ".popped"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    model_byte(b);
    check({tag, ".pop_width"}, 32'(ifc.nextdata_n), 32'd1);
    check_model(tag);
  endtask

  initial begin
    logic [7:0] b;
    int start_idx;
    int min_gap;
    bit drained;

    rst = 1'b1;
    ifc.ps2_ready = 1'b0;
    ifc.ps2_data  = 8'h00;
    model_reset();
    @(posedge clk); #1;
    check("rst.nextdata_n", 32'(ifc.nextdata_n), 32'd1);
    @(posedge clk); #1;
    check("rst.nextdata_n2", 32'(ifc.nextdata_n), 32'd1);
    check_model("rst");
    rst = 1'b0;

    // Simple keystroke, byte by byte
    send_one(8'h1C, "ks1");
    check("ks1.ascii_a", 32'(key_ascii), 32'h61);
    check("ks1.cnt", 32'({cnt_tens, cnt_ones}), 32'h01);
    send_one(8'hF0, "ks2");
    send_one(8'h1C, "ks3");
    check("ks3.down", 32'(key_down), 32'd0);
    check("ks3.cnt", 32'({cnt_tens, cnt_ones}), 32'h01);

    // Same keystroke as a burst: three pops, single-cycle, spaced >= 3
    do_reset();
    start_idx = pop_times.size();
    fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
    drained = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      @(posedge clk); #1;
      if (fifo.size() == 0) drained = 1'b1;
    end
    check("burst.drained", 32'(drained), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    model_byte(8'h1C); model_byte(8'hF0); model_byte(8'h1C);
    check("burst.pulses", 32'(pop_times.size() - start_idx), 32'd3);
    min_gap = 1000;
    for (int i = start_idx + 1; i < pop_times.size(); i++)
      if (pop_times[i] - pop_times[i-1] < min_gap) min_gap = pop_times[i] - pop_times[i-1];
    check("burst.min_gap_ge3", 32'(min_gap >= 3), 32'd1);
    check_model("burst");

    // Typematic repeat
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_one(8'h16, "rep");
      check("rep.ascii_1", 32'(key_ascii), 32'h31);
    end
    send_one(8'hF0, "rep_brk");
    send_one(8'h16, "rep_rel");
    check("rep.cnt", 32'({cnt_tens, cnt_ones}), 32'h01);
    check("rep.down", 32'(key_down), 32'd0);

    // Extended key, E0 F0 order on release
    do_reset();
    send_one(8'hE0, "ext1");
    send_one(8'h75, "ext2");
    check("ext.held_ext", 32'(key_ext), 32'd1);
    check("ext.held_code", 32'(key_code), 32'h75);
    check("ext.held_ascii", 32'(key_ascii), 32'h00);
    send_one(8'hE0, "ext3");
    send_one(8'hF0, "ext4");
    send_one(8'h75, "ext5");
    check("ext.released", 32'(key_down), 32'd0);
    check("ext.cnt", 32'({cnt_tens, cnt_ones}), 32'h01);

    // Extended break with F0 E0 order; plain make of same code is a different key
    send_one(8'hE0, "fe1"); send_one(8'h6B, "fe2");
    send_one(8'hF0, "fe3"); send_one(8'h6B, "fe4");
    check("fe.plain_brk_ignored", 32'(key_down), 32'd1);
    send_one(8'hF0, "fe5"); send_one(8'hE0, "fe6"); send_one(8'h6B, "fe7");
    check("fe.released", 32'(key_down), 32'd0);

    // Mismatched break, then reset during a POP cycle
    do_reset();
    send_one(8'h1C, "mm1");
    send_one(8'hF0, "mm2");
    send_one(8'h1A, "mm3");
    check("mm.still_code", 32'(key_code), 32'h1C);
    check("mm.still_down", 32'(key_down), 32'd1);
    fifo.push_back(8'h2B);
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk); #1;
      if (ifc.nextdata_n === 1'b0) drained = 1'b1;
    end
    check("rp.in_pop", 32'(drained), 32'd1);
    rst = 1'b1;
    #1;
    check("rp.nextdata_n", 32'(ifc.nextdata_n), 32'd1);
    @(posedge clk); #1;
    check("rp.fifo_kept", 32'(fifo.size()), 32'd1);
    rst = 1'b0;
    model_reset();
    check_model("rp.reset_vals");
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk); #1;
      if (ifc.nextdata_n === 1'b0) drained = 1'b1;
    end
    check("rp.repop", 32'(drained), 32'd1);
    @(posedge clk); #1;
    model_byte(8'h2B);
    check_model("rp.after");
    check("rp.fifo_empty", 32'(fifo.size()), 32'd0);
    check("rp.ascii_f", 32'(key_ascii), 32'h66);

    // Zero byte is an ordinary make code
    send_one(8'h00, "zero");

    // Randomized byte stream against the model
    do_reset();
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(9, 0))
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = 8'($urandom_range(255, 0));
        default: b = codes[$urandom_range(5, 0)];
      endcase
      send_one(b, "rnd");
    end

    // Counter wrap over 100 distinct make/break pairs
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send_one(codes[i % 36], "wr_mk");
      if (i == 8)  check("wr.cnt09", 32'({cnt_tens, cnt_ones}), 32'h09);
      if (i == 9)  check("wr.cnt10", 32'({cnt_tens, cnt_ones}), 32'h10);
      if (i == 98) check("wr.cnt99", 32'({cnt_tens, cnt_ones}), 32'h99);
      if (i == 99) check("wr.cnt00", 32'({cnt_tens, cnt_ones}), 32'h00);
      send_one(8'hF0, "wr_f0");
      send_one(codes[i % 36], "wr_bk");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
